// File: rtl/serial_to_parallel_buffer_pkg.sv
// serial_to_parallel_buffer_pkg: shared constants, state encoding and terminator test
package serial_to_parallel_buffer_pkg;
  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] PAD = 8'h00;
  localparam int MAX_BYTES_DEFAULT = 10;
  typedef enum logic [1:0] {IDLE, COLLECT, DISCARD} state_t;
  function automatic logic is_term(input logic [7:0] b);
    return (b == CR) || (b == LF);
  endfunction
endpackage

// File: rtl/serial_to_parallel_buffer_inactivity_timer.sv
// inactivity_timer: saturating idle counter that pulses expire on the cycle it reaches the limit
module inactivity_timer #(
  parameter int TIMEOUT_CYCLES = 1200000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  logic [W-1:0] cnt;
  // expire fires on the edge that would bring the count to the limit; a new byte always wins
  assign expire = enable && !clear && (cnt == W'(TIMEOUT_CYCLES - 1));
  // count idle cycles while enabled, restart on every received byte, hold at the limit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (enable && cnt != W'(TIMEOUT_CYCLES)) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/serial_to_parallel_buffer.sv
// serial_to_parallel_buffer: assembles terminator-delimited UART bytes into a held parallel frame
module serial_to_parallel_buffer
  import serial_to_parallel_buffer_pkg::*;
#(
  parameter int MAX_BYTES = MAX_BYTES_DEFAULT,
  parameter int TIMEOUT_CYCLES = 1200000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_byte,
  input  logic                   frame_ready,
  output logic                   frame_valid,
  output logic [8*MAX_BYTES-1:0] frame_data,
  output logic [3:0]             frame_len,
  output logic                   buffer_active,
  output logic                   overflow_err,
  output logic                   lost_err
);
  localparam int CW = $clog2(MAX_BYTES + 1);
  localparam logic [8*MAX_BYTES-1:0] EMPTY = {MAX_BYTES{PAD}};
  state_t state, state_n;
  logic [CW-1:0] count, count_n;
  logic [8*MAX_BYTES-1:0] work, work_n, first_byte;
  logic term, expire, complete, overflow_n;
  assign term = is_term(rx_byte);
  assign first_byte = {rx_byte, {(MAX_BYTES-1){PAD}}};
  assign buffer_active = state != IDLE;
  inactivity_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk(clk), .rst_n(rst_n), .clear(rx_valid), .enable(buffer_active), .expire(expire)
  );
  // assembly FSM: next state, working register and completion/overflow decisions
  always_comb begin
    state_n = state;
    count_n = count;
    work_n = work;
    complete = 1'b0;
    overflow_n = 1'b0;
    case (state)
      IDLE: if (rx_valid && !term) begin
        work_n = first_byte;
        count_n = CW'(1);
        state_n = COLLECT;
      end
      COLLECT: if (expire || (rx_valid && (term || count == CW'(MAX_BYTES)))) begin
        complete = rx_valid && term;
        overflow_n = rx_valid && !term;
        state_n = overflow_n ? DISCARD : IDLE;
        work_n = EMPTY;
        count_n = '0;
      end else if (rx_valid) begin
        work_n = work | (first_byte >> (8 * count));
        count_n = count + 1'b1;
      end
      DISCARD: if (expire || (rx_valid && term)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // assembly state and working register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      work <= EMPTY;
    end else begin
      state <= state_n;
      count <= count_n;
      work <= work_n;
    end
  end
  // output holding register with handshake and error pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_valid <= 1'b0;
      frame_data <= EMPTY;
      frame_len <= '0;
      overflow_err <= 1'b0;
      lost_err <= 1'b0;
    end else begin
      overflow_err <= overflow_n;
      lost_err <= complete && frame_valid && !frame_ready;
      if (complete && (!frame_valid || frame_ready)) begin
        frame_valid <= 1'b1;
        frame_data <= work;
        frame_len <= 4'(count);
      end else if (frame_ready) frame_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_serial_to_parallel_buffer.sv
// tb_serial_to_parallel_buffer: directed and random frames checked against a queue-based model
module tb_serial_to_parallel_buffer;
  localparam int MAX = 10;
  localparam int TO = 16;
  logic clk = 0, rst_n = 0, rx_valid = 0, frame_ready = 0;
  logic [7:0] rx_byte = 0;
  logic frame_valid, buffer_active, overflow_err, lost_err;
  logic [8*MAX-1:0] frame_data;
  logic [3:0] frame_len;
  int compared = 0, mismatched = 0;
  byte unsigned q[$];
  int mode = 0, idle = 0;
  logic m_valid = 0, m_ovf = 0, m_lost = 0;
  logic [8*MAX-1:0] m_data = 0;
  logic [3:0] m_len = 0;
  int n_ovf = 0, n_lost = 0, n_frames = 0;

  serial_to_parallel_buffer #(.MAX_BYTES(MAX), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .frame_ready(frame_ready), .frame_valid(frame_valid), .frame_data(frame_data),
    .frame_len(frame_len), .buffer_active(buffer_active),
    .overflow_err(overflow_err), .lost_err(lost_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [8*MAX-1:0] got, input logic [8*MAX-1:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mode = 0; idle = 0;
    m_valid = 0; m_data = 0; m_len = 0; m_ovf = 0; m_lost = 0;
  endtask

  task automatic model_step(input logic v, input byte unsigned b, input logic r);
    bit term, done;
    byte unsigned fr[$];
    term = (b == 8'h0D) || (b == 8'h0A);
    done = 0;
    m_ovf = 0;
    m_lost = 0;
    if (v) idle = 0;
    if (mode == 0) begin
      if (v && !term) begin q = {b}; mode = 1; end
    end else if (v) begin
      if (mode == 1 && term) begin done = 1; fr = q; q.delete(); mode = 0; end
      else if (mode == 1 && q.size() == MAX) begin m_ovf = 1; q.delete(); mode = 2; end
      else if (mode == 1) q.push_back(b);
      else if (term) mode = 0;
    end else begin
      idle++;
      if (idle >= TO) begin q.delete(); mode = 0; end
    end
    if (done && (!m_valid || r)) begin
      m_valid = 1;
      m_data = 0;
      foreach (fr[i]) m_data[8*(MAX-1-i) +: 8] = fr[i];
      m_len = 4'(fr.size());
    end else if (done) m_lost = 1;
    else if (r) m_valid = 0;
  endtask

  task automatic compare_all();
    check("frame_valid", 80'(frame_valid), 80'(m_valid));
    check("frame_data", frame_data, m_data);
    check("frame_len", 80'(frame_len), 80'(m_len));
    check("buffer_active", 80'(buffer_active), 80'(mode != 0));
    check("overflow_err", 80'(overflow_err), 80'(m_ovf));
    check("lost_err", 80'(lost_err), 80'(m_lost));
  endtask

  task automatic cycle(input logic v, input byte unsigned b, input logic r);
    rx_valid = v; rx_byte = b; frame_ready = r;
    @(posedge clk);
    model_step(v, b, r);
    #1;
    compare_all();
    n_ovf += int'(overflow_err);
    n_lost += int'(lost_err);
    n_frames += int'(frame_valid && frame_ready);
  endtask

  task automatic send(input string s, input logic r);
    for (int i = 0; i < s.len(); i++) cycle(1, s[i], r);
  endtask

  task automatic idle_cycles(input int n, input logic r);
    for (int i = 0; i < n; i++) cycle(0, 8'h00, r);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 compare_all();
    rst_n = 1;
    send("1234567890", 1); cycle(1, 8'h0D, 1);
    check("len10", 80'(frame_len), 80'd10);
    check("data10", frame_data, 80'h31323334353637383930);
    idle_cycles(1, 1);
    check("valid_one_cycle", 80'(frame_valid), 80'd0);
    send("AB", 1); cycle(1, 8'h0A, 0);
    check("data_ab", frame_data, {16'h4142, 64'h0});
    idle_cycles(2, 1);
    cycle(1, 8'h0D, 1); idle_cycles(1, 1);
    check("lone_cr", 80'(frame_valid), 80'd0);
    n_ovf = 0;
    send("ABCDEFGHIJK", 1); send("XY", 1); cycle(1, 8'h0D, 1); idle_cycles(1, 1);
    check("ovf_once", 80'(n_ovf), 80'd1);
    check("ovf_no_frame", 80'(frame_valid), 80'd0);
    send("Z", 1); cycle(1, 8'h0D, 0);
    check("z_frame", frame_data, {8'h5A, 72'h0});
    n_lost = 0;
    idle_cycles(1, 1);
    send("A", 0); cycle(1, 8'h0D, 0);
    send("B", 0); cycle(1, 8'h0D, 0); idle_cycles(1, 0);
    check("held_a", frame_data, {8'h41, 72'h0});
    check("lost_once", 80'(n_lost), 80'd1);
    send("C", 0); cycle(1, 8'h0D, 1);
    check("c_no_gap", {frame_valid, frame_data[79:72]}, {1'b1, 8'h43});
    idle_cycles(1, 1);
    send("Q", 1); idle_cycles(TO, 1); send("R", 1); cycle(1, 8'h0D, 1);
    check("timeout_r", {frame_len, frame_data}, {4'd1, 8'h52, 72'h0});
    send("ABC", 1);
    #2 rst_n = 0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk); #1 rst_n = 1;
    n_ovf = 0; n_lost = 0;
    send("D", 1); cycle(1, 8'h0D, 1);
    check("after_reset_d", {frame_len, frame_data}, {4'd1, 8'h44, 72'h0});
    check("no_err_pulses", 80'(n_ovf + n_lost), 80'd0);
    for (int i = 0; i < 3000; i++) begin
      int sel;
      byte unsigned b;
      sel = int'($urandom_range(0, 99));
      b = 8'(8'h41 + $urandom_range(0, 25));
      if (sel < 8) b = 8'h0D;
      else if (sel < 12) b = 8'h0A;
      if (sel >= 97) idle_cycles(int'($urandom_range(TO - 2, TO + 2)), 1'($urandom));
      cycle(1'($urandom_range(0, 2) != 0), b, 1'($urandom_range(0, 3) != 0));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
